// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared widths, the sequencer state encoding and the program start-address
// table used by pc_sequencer and its interface.
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int PC_W  = 10;
  localparam int CYC_W = 16;
  localparam int TKN_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pcs_state_t;

  // Start address of each selectable program, indexed by prog_sel.
  localparam logic [PC_W-1:0] PROG_BASE [4] = '{
    10'd0, 10'd128, 10'd256, 10'd384
  };

  // Table lookup wrapped in a function so callers need no array indexing.
  function automatic logic [PC_W-1:0] progBase(input logic [1:0] sel);
    return PROG_BASE[sel];
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
// Bundles the sequencer's control inputs and status outputs.
//   master : drives start/prog_sel/stall/halt_instr/branch/address,
//            observes pc/running/done/cycle_count/taken_count
//   slave  : the sequencer itself (opposite directions)
// ---------------------------------------------------------------------------
interface pc_sequencer_if
  import cpu_pkg::*;
#(
  parameter int PcW  = PC_W,
  parameter int CycW = CYC_W,
  parameter int TknW = TKN_W
);

  logic            start;
  logic [1:0]      prog_sel;
  logic            stall;
  logic            halt_instr;
  logic            branch;
  logic [PcW-1:0]  address;

  logic [PcW-1:0]  pc;
  logic            running;
  logic            done;
  logic [CycW-1:0] cycle_count;
  logic [TknW-1:0] taken_count;

  modport master (
    output start, prog_sel, stall, halt_instr, branch, address,
    input  pc, running, done, cycle_count, taken_count
  );

  modport slave (
    input  start, prog_sel, stall, halt_instr, branch, address,
    output pc, running, done, cycle_count, taken_count
  );

endinterface

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : count up by one when not saturated
//   q          : current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear first, otherwise increment unless already full.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Program counter and run sequencer. Launches a program from the start
// address table, then each RUN cycle holds (stall), stops (halt), redirects
// (branch) or steps the PC. Reports done and saturating cycle/taken counts.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pc_sequencer_if.slave (controls in, pc/status/counts out)
// ---------------------------------------------------------------------------
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int PcW  = PC_W,
  parameter int CycW = CYC_W,
  parameter int TknW = TKN_W
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.slave  bus
);

  pcs_state_t     state_q, state_d;
  logic [PcW-1:0] pc_q, pc_d;

  logic cycClr, cycInc;
  logic tknClr, tknInc;

  // Next state, next PC and counter controls. In RUN every cycle counts,
  // and stall beats halt beats branch beats the plain step. start is only
  // looked at from IDLE/DONE, so a start coinciding with halt is dropped.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cycClr  = 1'b0;
    cycInc  = 1'b0;
    tknClr  = 1'b0;
    tknInc  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = PcW'(progBase(bus.prog_sel));
          cycClr  = 1'b1;
          tknClr  = 1'b1;
        end
      end
      RUN: begin
        cycInc = 1'b1;
        if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.halt_instr) begin
          state_d = DONE;
        end else if (bus.branch) begin
          pc_d   = bus.address;
          tknInc = 1'b1;
        end else begin
          pc_d = pc_q + PcW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  sat_counter #(.W(CycW)) uCycleCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cycClr),
    .inc   (cycInc),
    .q     (bus.cycle_count)
  );

  sat_counter #(.W(TknW)) uTakenCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tknClr),
    .inc   (tknInc),
    .q     (bus.taken_count)
  );

  assign bus.pc      = pc_q;
  assign bus.running = (state_q == RUN);
  assign bus.done    = (state_q == DONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Directed bench for pc_sequencer. Each step drives inputs on the falling
// edge, advances a behavioural reference model, queues the expected outputs
// and compares them against the DUT just after the next rising edge.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;
  import cpu_pkg::*;

  typedef struct {
    logic [9:0]  pc;
    logic        running;
    logic        done;
    logic [15:0] cyc;
    logic [7:0]  tkn;
  } expect_t;

  logic clk;
  logic rst_n;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  expect_t expQ [$];
  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Reference model state
  int          mState;   // 0 idle, 1 run, 2 done
  logic [9:0]  mPc;
  logic [15:0] mCyc;
  logic [7:0]  mTkn;

  task automatic modelReset();
    mState = 0;
    mPc    = 10'd0;
    mCyc   = 16'd0;
    mTkn   = 8'd0;
  endtask

  task automatic pushExpected();
    expect_t e;
    e.pc      = mPc;
    e.running = (mState == 1);
    e.done    = (mState == 2);
    e.cyc     = mCyc;
    e.tkn     = mTkn;
    expQ.push_back(e);
  endtask

  // One clock edge of the reference behaviour for the currently driven inputs.
  task automatic modelStep(input logic st, input logic [1:0] sel, input logic stl,
                           input logic hlt, input logic br, input logic [9:0] addr);
    if (mState != 1) begin
      if (st) begin
        mState = 1;
        mPc    = {1'b0, sel, 7'd0};
        mCyc   = 16'd0;
        mTkn   = 8'd0;
      end
    end else begin
      if (mCyc != 16'hFFFF) mCyc = mCyc + 16'd1;
      if (stl) begin
        mPc = mPc;
      end else if (hlt) begin
        mState = 2;
      end else if (br) begin
        mPc = addr;
        if (mTkn != 8'hFF) mTkn = mTkn + 8'd1;
      end else begin
        mPc = mPc + 10'd1;
      end
    end
  endtask

  task automatic checkField(input string tag, input string field,
                            input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s.%s: observed 0x%0h expected 0x%0h", tag, field, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    expect_t e;
    if (expQ.size() == 0) begin
      checkCount++;
      failCount++;
      $error("[TB] FAIL %s.queue: observed empty expected entry", tag);
    end else begin
      e = expQ.pop_front();
      checkField(tag, "pc",      32'(bus.pc),          32'(e.pc));
      checkField(tag, "running", 32'(bus.running),     32'(e.running));
      checkField(tag, "done",    32'(bus.done),        32'(e.done));
      checkField(tag, "cycle",   32'(bus.cycle_count), 32'(e.cyc));
      checkField(tag, "taken",   32'(bus.taken_count), 32'(e.tkn));
    end
  endtask

  task automatic applyStimulus(input string tag, input logic st, input logic [1:0] sel,
                               input logic stl, input logic hlt, input logic br,
                               input logic [9:0] addr);
    @(negedge clk);
    bus.start      = st;
    bus.prog_sel   = sel;
    bus.stall      = stl;
    bus.halt_instr = hlt;
    bus.branch     = br;
    bus.address    = addr;
    modelStep(st, sel, stl, hlt, br, addr);
    pushExpected();
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.prog_sel   = 2'd0;
    bus.stall      = 1'b0;
    bus.halt_instr = 1'b0;
    bus.branch     = 1'b0;
    bus.address    = 10'd0;
    rst_n          = 1'b0;

    // Reset state, then a start request held during reset must do nothing
    #1;
    modelReset();
    pushExpected();
    checkOutput("reset");
    bus.start    = 1'b1;
    bus.prog_sel = 2'd1;
    pushExpected();
    @(posedge clk);
    #1;
    checkOutput("start_in_reset");
    @(negedge clk);
    bus.start = 1'b0;
    rst_n     = 1'b1;

    // Launch program 1, then three free steps
    applyStimulus("launch", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 10'h000);
    for (int i = 0; i < 3; i++)
      applyStimulus("free_step", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 10'h000);

    // Branch, then a branch masked by stall
    applyStimulus("branch", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 10'h048);
    applyStimulus("branch_stall", 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 10'h100);

    // Walk up to 0x050
    for (int i = 0; i < 8; i++)
      applyStimulus("walk", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 10'h000);

    // Halt beats branch; start in the same cycle is ignored
    applyStimulus("halt", 1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 10'h200);
    applyStimulus("done_hold", 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 10'h300);

    // Relaunch program 2; start while running is ignored
    applyStimulus("relaunch", 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 10'h000);
    applyStimulus("start_in_run", 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 10'h000);
    applyStimulus("stall", 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 10'h000);

    // PC wrap at the top of the address space
    applyStimulus("to_top", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 10'h3FF);
    applyStimulus("wrap", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 10'h000);

    // Taken counter runs into saturation
    for (int i = 0; i < 256; i++)
      applyStimulus("tkn_sat", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 10'($urandom_range(0, 1023)));

    // Cycle counter saturation, preloaded to all-ones
    @(negedge clk);
    force dut.uCycleCnt.count_q = 16'hFFFF;
    #1;
    release dut.uCycleCnt.count_q;
    mCyc = 16'hFFFF;
    applyStimulus("cyc_sat", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 10'h000);
    applyStimulus("cyc_sat2", 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 10'h000);

    // Asynchronous reset between edges while running
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    pushExpected();
    checkOutput("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Launch program 3 after the abort
    applyStimulus("launch3", 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 10'h000);
    applyStimulus("step3", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 10'h000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
